// File: rtl/blink_driver_pkg.sv
// Shared definitions for the blink driver.
//   blink_state_e : FSM state encoding (IDLE / ON / OFF)
//   cnt_width()   : bit width of a down-counter that must hold cycles-1
package blink_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } blink_state_e;

    // Counter holds values 0..cycles-1, so $clog2(cycles) bits suffice;
    // at least one bit so a 1-cycle phase still has a real register.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        if (cycles <= 1) begin
            return 1;
        end
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Loadable down-counter for blink phase timing.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset (count -> 0)
//   load     : load load_val this cycle (priority over counting)
//   load_val : value loaded; phase lasts load_val+1 cycles
//   done     : count has reached zero (decode of the count register)
module blink_timer #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Holds at zero rather than wrapping.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/blink_driver.sv
// LED blink driver with a saturating request queue.
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   trigger  : one request per cycle it is high
//   cancel   : synchronous abort of current blink and queued requests
//   led      : registered LED drive
//   busy     : state is not IDLE
//   pending  : queued requests not yet started
//   overflow : one-cycle pulse when a request is dropped at saturation
module blink_driver
    import blink_driver_pkg::*;
#(
    parameter int unsigned ON_CYCLES   = 5_000_000,
    parameter int unsigned OFF_CYCLES  = 5_000_000,
    parameter int unsigned MAX_PENDING = 15
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               trigger,
    input  logic                               cancel,
    output logic                               led,
    output logic                               busy,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
    output logic                               overflow
);

    localparam int unsigned TW = cnt_width((ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES);
    localparam int unsigned PW = $clog2(MAX_PENDING + 1);
    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

    blink_state_e    state_q, state_d;
    logic [PW-1:0]   pending_q, pending_d;
    logic            led_q, led_d;
    logic            overflow_q, overflow_d;
    logic            timer_load;
    logic [TW-1:0]   timer_val;
    logic            timer_done;

    blink_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        overflow_d = 1'b0;

        if (cancel) begin
            state_d   = ST_IDLE;
            pending_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        state_d = ST_ON;
                    end
                end
                ST_ON: begin
                    if (timer_done) begin
                        state_d = ST_OFF;
                    end
                    if (trigger) begin
                        if (pending_q == PEND_MAX) begin
                            overflow_d = 1'b1;
                        end else begin
                            pending_d = pending_q + PW'(1);
                        end
                    end
                end
                ST_OFF: begin
                    if (timer_done) begin
                        // A trigger arriving with the dequeue takes the freed
                        // slot, so pending stays put. With an empty queue it
                        // starts the next blink directly instead of being
                        // stranded in IDLE.
                        if (pending_q != '0) begin
                            state_d = ST_ON;
                            if (!trigger) begin
                                pending_d = pending_q - PW'(1);
                            end
                        end else if (trigger) begin
                            state_d = ST_ON;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (trigger) begin
                        if (pending_q == PEND_MAX) begin
                            overflow_d = 1'b1;
                        end else begin
                            pending_d = pending_q + PW'(1);
                        end
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    pending_d = '0;
                end
            endcase
        end

        // Timer is reloaded on every state entry.
        timer_load = (state_d != state_q);
        case (state_d)
            ST_ON:   timer_val = ON_LOAD;
            ST_OFF:  timer_val = OFF_LOAD;
            default: timer_val = '0;
        endcase

        led_d = (state_d == ST_ON);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            led_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            led_q      <= led_d;
            overflow_q <= overflow_d;
        end
    end

    assign led      = led_q;
    assign busy     = (state_q != ST_IDLE);
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: doc/blink_driver.md
BLINK_DRIVER -- requirements
Module: blink_driver

Interface
REQ-001 Parameter ON_CYCLES, default 5_000_000, is the LED on-time per blink in clk cycles; legal range is 1 or more.
REQ-002 Parameter OFF_CYCLES, default 5_000_000, is the minimum LED off-gap after each blink in clk cycles; legal range is 1 or more.
REQ-003 Parameter MAX_PENDING, default 15, is the saturation limit of queued blink requests; legal range is 1..255.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 trigger  input  1  single-cycle blink request, typically a debounced edge pulse (p_edge).
REQ-007 cancel  input  1  synchronous abort; drops the current blink and all queued requests.
REQ-008 led  output  1  registered indicator drive.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 pending  output  $clog2(MAX_PENDING+1)  count of queued requests not yet started.
REQ-011 overflow  output  1  one-cycle pulse when a trigger is dropped because pending is saturated.

Function
REQ-012 The FSM SHALL have three states: IDLE, ON and OFF.
REQ-013 IDLE to ON: trigger sampled high in IDLE loads the timer; led is 1 from the next cycle.
REQ-014 ON state: led is 1 for exactly ON_CYCLES cycles, then the FSM moves to OFF and led is 0.
REQ-015 OFF state: led is 0 for exactly OFF_CYCLES cycles.
REQ-016 OFF end with pending > 0: decrement pending and enter ON directly, with no IDLE cycle.
REQ-017 OFF end with pending = 0: enter IDLE.
REQ-018 Trigger sampled in ON or OFF: pending increments by 1.
REQ-019 Trigger on the same cycle as an OFF-end dequeue: pending is unchanged and the new blink starts.
REQ-020 Saturation: a trigger arriving while pending = MAX_PENDING, with no same-cycle dequeue, is dropped and overflow pulses high for 1 cycle.
REQ-021 cancel has priority over trigger and dequeue; next cycle state = IDLE, led = 0, pending = 0, overflow = 0.
REQ-022 Timer sizing: one down-counter of width $clog2(max(ON_CYCLES,OFF_CYCLES)); it never wraps and is reloaded on every state entry.
REQ-023 A trigger held high for N cycles counts as N requests; the block performs no edge detection.
REQ-024 Outputs are glitch-free: led, busy and overflow are flop outputs or decodes of flops only.

Reset
REQ-025 Reset asserted (low) immediately forces state = IDLE, led = 0, busy = 0, pending = 0, overflow = 0, timer = 0, independent of clk.
REQ-026 Reset asserted mid-blink aborts the blink with no further led pulse; the first trigger after release starts a fresh full-length blink.
REQ-027 After reset deassertion, the first rising edge may sample trigger.

Structure
REQ-028 A shared package holds the state enumeration and a helper function returning the counter width for a given cycle count.
REQ-029 One sub-module, blink_timer, is natural: a loadable down-counter that outputs a done flag.
REQ-030 The sub-module and the FSM together fit within 120-400 RTL lines.

Verification
All scenarios use ON_CYCLES=3, OFF_CYCLES=2, MAX_PENDING=3.
REQ-031 Single blink: trigger pulse at cycle 10 -> led high cycles 11-13, low 14-15, busy low from cycle 16.
REQ-032 Back-to-back: triggers at cycles 10 and 12 -> pending=1 at cycle 13; second blink led high cycles 16-18; IDLE at cycle 21.
REQ-033 Saturation: 5 triggers during the first blink -> pending stops at 3, overflow pulses once for the 5th trigger, exactly 4 blinks total.
REQ-034 Cancel: cancel at cycle 12 with pending=2 -> led=0 and pending=0 at cycle 13; no further blinks occur.
REQ-035 Async reset: reset low between clock edges during ON -> led drops before the next edge; after release, a trigger gives a full 3-cycle blink.
REQ-036 Simultaneous events: trigger on the OFF-end cycle with pending=1 -> pending stays 1 and the next blink starts with no gap beyond OFF_CYCLES.
